feature_table_arbiter: RTL and testbench

- Owns the per-label feature table of the RLECCA stage. Shares one read port and one write port of that table between three requesters:
  - accumulator write-back;
  - merge fetch, which feeds dp/ep/DMG into the feature accumulator;
  - component emit, which reads a finished label, streams it out and re-initialises the entry.
- Performs a table-clear sweep after reset.
- Sits between the label/merge logic and the feature accumulator, ahead of the feature output stream.

---
 rtl/rlecca_pkg.sv | 29 ++
 rtl/feature_table_arbiter_if.sv | 54 +++++
 rtl/feature_table_ram.sv | 47 ++++
 rtl/feature_table_arbiter.sv | 177 +++++++++++++++++
 tb/tb_feature_table_arbiter.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rlecca_pkg.sv
// Shared widths, entry INIT word and emit-FSM states
// for the RLECCA feature table.
package rlecca_pkg;

  localparam int ADDRESS_BIT = 8;
  localparam int X_BIT       = 9;
  localparam int Y_BIT       = 9;
  localparam int DATA_BIT    = 38;
  localparam int EXTRA_BIT   = 19;

  typedef enum logic [1:0] {
    EM_IDLE,
    EM_RD,
    EM_CLR,
    EM_HOLD
  } emit_st_e;

  // Empty box {minx=all ones, maxx=0, miny=all ones, maxy=0}.
  // Returned right-aligned in 64 bits; callers cut to 2*xb+2*yb.
  function automatic logic [63:0] feat_init(input int xb,
                                             input int yb);
    logic [63:0] ones_x;
    logic [63:0] ones_y;
    ones_x = (64'd1 << xb) - 64'd1;
    ones_y = (64'd1 << yb) - 64'd1;
    return (ones_x << (xb + 2 * yb)) | (ones_y << yb);
  endfunction

endpackage

// File: rtl/feature_table_arbiter_if.sv
// Request/grant and output-stream bundle of the
// feature table arbiter.
interface feature_table_arbiter_if
  import rlecca_pkg::*;
#(
  parameter int address_bit = ADDRESS_BIT,
  parameter int data_bit    = DATA_BIT,
  parameter int extra_bit   = EXTRA_BIT
);

  logic                   busy;

  logic                   wb_req;
  logic [address_bit-1:0] wb_addr;
  logic [data_bit-1:0]    wb_d;
  logic [extra_bit-1:0]   wb_e;
  logic                   wb_ack;

  logic                   mg_req;
  logic [address_bit-1:0] mg_addr;
  logic                   mg_ack;
  logic                   DMG;
  logic [data_bit-1:0]    dp;
  logic [extra_bit-1:0]   ep;

  logic                   done_req;
  logic [address_bit-1:0] done_addr;
  logic                   done_ack;
  logic [extra_bit-1:0]   min_area;

  logic                   out_valid;
  logic                   out_ready;
  logic [data_bit-1:0]    out_d;
  logic [extra_bit-1:0]   out_e;

  modport master (
    output wb_req, wb_addr, wb_d, wb_e,
    output mg_req, mg_addr,
    output done_req, done_addr, min_area,
    output out_ready,
    input  busy, wb_ack, mg_ack, DMG, dp, ep,
    input  done_ack, out_valid, out_d, out_e
  );

  modport slave (
    input  wb_req, wb_addr, wb_d, wb_e,
    input  mg_req, mg_addr,
    input  done_req, done_addr, min_area,
    input  out_ready,
    output busy, wb_ack, mg_ack, DMG, dp, ep,
    output done_ack, out_valid, out_d, out_e
  );

endinterface

// File: rtl/feature_table_ram.sv
// 1R1W table, synchronous read, a same-cycle write to the
// read address is forwarded so the reader never sees stale data.
module feature_table_ram #(
  parameter int address_bit = 8,
  parameter int word_bit    = 57
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   we_i,
  input  logic [address_bit-1:0] waddr_i,
  input  logic [word_bit-1:0]    wdata_i,
  input  logic                   re_i,
  input  logic [address_bit-1:0] raddr_i,
  output logic [word_bit-1:0]    rdata_o
);

  logic [word_bit-1:0] mem_q [2**address_bit];
  logic [word_bit-1:0] rdata_q;
  logic [word_bit-1:0] rdata_d;

  // Forward the write word when it targets the read address.
  always_comb begin
    rdata_d = mem_q[raddr_i];
    if (we_i && (waddr_i == raddr_i)) begin
      rdata_d = wdata_i;
    end
  end

  // Storage array write.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read register, only moves on an actual read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/feature_table_arbiter.sv
// Shares the feature table ports between write-back, merge
// fetch and component emit; clears the table after reset.
module feature_table_arbiter
  import rlecca_pkg::*;
#(
  parameter int address_bit = ADDRESS_BIT,
  parameter int x_bit       = X_BIT,
  parameter int y_bit       = Y_BIT,
  parameter int data_bit    = DATA_BIT,
  parameter int extra_bit   = EXTRA_BIT
) (
  input logic clk,
  input logic rst,
  feature_table_arbiter_if.slave bus
);

  localparam int W = data_bit + extra_bit;
  localparam logic [data_bit-1:0] INIT_D =
    data_bit'(feat_init(x_bit, y_bit));
  localparam logic [W-1:0] INIT_W =
    {INIT_D, {extra_bit{1'b0}}};

  logic                   busy_q;
  logic [address_bit-1:0] sweep_q;
  emit_st_e               st_q;
  logic [address_bit-1:0] em_addr_q;
  logic [extra_bit-1:0]   min_q;
  logic                   keep_q;
  logic                   dmg_q;
  logic                   out_valid_q;
  logic [data_bit-1:0]    out_d_q;
  logic [extra_bit-1:0]   out_e_q;

  logic                   wb_win;
  logic                   clr_win;
  logic                   mg_win;
  logic                   em_rd;
  logic                   we;
  logic [address_bit-1:0] waddr;
  logic [W-1:0]           wdata;
  logic                   re;
  logic [address_bit-1:0] raddr;
  logic [W-1:0]           rdata;
  logic [data_bit-1:0]    rd_d;
  logic [extra_bit-1:0]   rd_e;

  // Write port: sweep, then write-back, then emit clear.
  assign wb_win  = !busy_q && bus.wb_req;
  assign clr_win = !busy_q && !bus.wb_req &&
                   (st_q == EM_CLR);

  // Read port: merge fetch beats emit read.
  assign mg_win = !busy_q && bus.mg_req;
  assign em_rd  = !busy_q && !bus.mg_req &&
                  bus.done_req && (st_q == EM_IDLE);

  // Write-port mux; the three winners are exclusive.
  always_comb begin
    we    = 1'b0;
    waddr = em_addr_q;
    wdata = INIT_W;
    unique case (1'b1)
      busy_q: begin
        we    = 1'b1;
        waddr = sweep_q;
        wdata = INIT_W;
      end
      wb_win: begin
        we    = 1'b1;
        waddr = bus.wb_addr;
        wdata = {bus.wb_d, bus.wb_e};
      end
      clr_win: begin
        we    = 1'b1;
        waddr = em_addr_q;
        wdata = INIT_W;
      end
      default: ;
    endcase
  end

  assign re    = mg_win || em_rd;
  assign raddr = mg_win ? bus.mg_addr : bus.done_addr;

  feature_table_ram #(
    .address_bit (address_bit),
    .word_bit    (W)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .we_i    (we),
    .waddr_i (waddr),
    .wdata_i (wdata),
    .re_i    (re),
    .raddr_i (raddr),
    .rdata_o (rdata)
  );

  assign rd_d = rdata[W-1:extra_bit];
  assign rd_e = rdata[extra_bit-1:0];

  // Post-reset clear sweep, one entry per cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q  <= 1'b1;
      sweep_q <= '0;
    end else if (busy_q) begin
      sweep_q <= sweep_q + 1'b1;
      if (&sweep_q) begin
        busy_q <= 1'b0;
      end
    end
  end

  // Merge data strobe, one cycle behind the read grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dmg_q <= 1'b0;
    end else begin
      dmg_q <= mg_win;
    end
  end

  // Emit FSM: read, capture, clear entry, then offer downstream.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q        <= EM_IDLE;
      em_addr_q   <= '0;
      min_q       <= '0;
      keep_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_d_q     <= '0;
      out_e_q     <= '0;
    end else begin
      unique case (st_q)
        EM_IDLE: begin
          if (em_rd) begin
            st_q      <= EM_RD;
            em_addr_q <= bus.done_addr;
            min_q     <= bus.min_area;
          end
        end
        EM_RD: begin
          out_d_q <= rd_d;
          out_e_q <= rd_e;
          keep_q  <= (rd_e >= min_q);
          st_q    <= EM_CLR;
        end
        EM_CLR: begin
          if (clr_win) begin
            st_q        <= keep_q ? EM_HOLD : EM_IDLE;
            out_valid_q <= keep_q;
          end
        end
        EM_HOLD: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            st_q        <= EM_IDLE;
          end
        end
        default: st_q <= EM_IDLE;
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.wb_ack    = wb_win;
  assign bus.mg_ack    = mg_win;
  assign bus.done_ack  = em_rd;
  assign bus.DMG       = dmg_q;
  assign bus.dp        = rd_d;
  assign bus.ep        = rd_e;
  assign bus.out_valid = out_valid_q;
  assign bus.out_d     = out_d_q;
  assign bus.out_e     = out_e_q;

endmodule

// File: tb/tb_feature_table_arbiter.sv
// Scoreboard bench for feature_table_arbiter: stimulus
// queues expected merge/emit words, a monitor pops them.
module tb_feature_table_arbiter;

  localparam int AW = 8;
  localparam int DW = 38;
  localparam int EW = 19;
  localparam int W  = DW + EW;

  localparam logic [DW-1:0] INIT_D =
    {9'h1FF, 9'h000, 9'h1FF, 9'h000};
  localparam logic [W-1:0] INIT_W = {INIT_D, 19'd0};

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   npass = 0;
  int   ntot = 0;

  logic [W-1:0] mg_q[$];
  logic [W-1:0] out_q[$];

  feature_table_arbiter_if bus ();

  feature_table_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] bb(input int a, input int b,
                                       input int c, input int d);
    return {9'(a), 9'(b), 9'(c), 9'(d)};
  endfunction

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h",
                  name, act, exp);
  endtask

  task automatic wait_ack(input int kind, output int t);
    t = -1;
    for (int i = 0; i < 400 && t < 0; i++) begin
      @(negedge clk);
      if (kind == 0 && bus.wb_ack) t = cyc;
      if (kind == 1 && bus.mg_ack) t = cyc;
      if (kind == 2 && bus.done_ack) t = cyc;
      @(posedge clk);
      #1;
    end
    if (t < 0) chk("ack_timeout", 64'(kind), 64'd99);
  endtask

  task automatic wb_op(input logic [AW-1:0] a,
                       input logic [DW-1:0] d,
                       input logic [EW-1:0] e,
                       output int t);
    bus.wb_addr = a;
    bus.wb_d = d;
    bus.wb_e = e;
    bus.wb_req = 1'b1;
    wait_ack(0, t);
    bus.wb_req = 1'b0;
  endtask

  task automatic mg_op(input logic [AW-1:0] a,
                       input logic [W-1:0] exp,
                       output int t);
    mg_q.push_back(exp);
    bus.mg_addr = a;
    bus.mg_req = 1'b1;
    wait_ack(1, t);
    bus.mg_req = 1'b0;
  endtask

  task automatic done_op(input logic [AW-1:0] a,
                         input logic [EW-1:0] mn,
                         input bit keep,
                         input logic [W-1:0] exp,
                         output int t);
    if (keep) out_q.push_back(exp);
    bus.done_addr = a;
    bus.min_area = mn;
    bus.done_req = 1'b1;
    wait_ack(2, t);
    bus.done_req = 1'b0;
  endtask

  // Monitor: DMG timing, merge data and emitted words.
  always @(negedge clk) begin : mon
    logic [W-1:0] ex;
    logic         ack_d;
    if (rst) begin
      ack_d = 1'b0;
    end else begin
      if (bus.DMG || ack_d) chk("dmg_timing", 64'(bus.DMG), 64'(ack_d));
      if (bus.DMG) begin
        if (mg_q.size() == 0) begin
          chk("dmg_unexpected", 64'd1, 64'd0);
        end else begin
          ex = mg_q.pop_front();
          chk("dp", 64'(bus.dp), 64'(ex[W-1:EW]));
          chk("ep", 64'(bus.ep), 64'(ex[EW-1:0]));
        end
      end
      if (bus.out_valid) begin
        if (out_q.size() == 0) begin
          chk("out_unexpected", 64'd1, 64'd0);
        end else begin
          ex = out_q[0];
          chk("out_d", 64'(bus.out_d), 64'(ex[W-1:EW]));
          chk("out_e", 64'(bus.out_e), 64'(ex[EW-1:0]));
          if (bus.out_ready) void'(out_q.pop_front());
        end
      end
      ack_d = bus.mg_ack;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, t_idle, tw, tm, td, t1, t2, t3;
    bit seen;
    bus.wb_req = 0; bus.wb_addr = '0; bus.wb_d = '0; bus.wb_e = '0;
    bus.mg_req = 0; bus.mg_addr = '0;
    bus.done_req = 0; bus.done_addr = '0; bus.min_area = '0;
    bus.out_ready = 1'b1;

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 64'(bus.busy), 64'd1);
    chk("rst_wb_ack", 64'(bus.wb_ack), 64'd0);
    chk("rst_mg_ack", 64'(bus.mg_ack), 64'd0);
    chk("rst_done_ack", 64'(bus.done_ack), 64'd0);
    chk("rst_dmg", 64'(bus.DMG), 64'd0);
    chk("rst_dp", 64'(bus.dp), 64'd0);
    chk("rst_ep", 64'(bus.ep), 64'd0);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_d", 64'(bus.out_d), 64'd0);
    chk("rst_out_e", 64'(bus.out_e), 64'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Reset in the middle of the sweep restarts it
    repeat (100) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rerst_busy", 64'(bus.busy), 64'd1);
    @(posedge clk); #1 rst = 1'b0;

    // Full sweep length; held requests wait for busy to drop
    fork
      begin
        n = 0; t_idle = -1;
        for (int i = 0; i < 400 && t_idle < 0; i++) begin
          @(negedge clk);
          if (bus.busy) n++;
          else t_idle = cyc;
        end
      end
      wb_op(8'd3, bb(1, 1, 1, 1), 19'd99, tw);
      mg_op(8'd3, {bb(1, 1, 1, 1), 19'd99}, tm);
    join
    chk("sweep_len", 64'(n), 64'd256);
    chk("wb_after_busy", 64'(tw), 64'(t_idle));
    chk("mg_after_busy", 64'(tm), 64'(t_idle));

    // Idle entries read INIT; back-to-back merges
    mg_op(8'd0, INIT_W, t1);
    mg_op(8'd200, INIT_W, t2);
    mg_op(8'd255, INIT_W, t3);
    chk("b2b_mg_1", 64'(t2 - t1), 64'd1);
    chk("b2b_mg_2", 64'(t3 - t2), 64'd1);

    // Write-back then merge fetch of label 5
    wb_op(8'd5, bb(10, 20, 3, 7), 19'd42, tw);
    mg_op(8'd5, {bb(10, 20, 3, 7), 19'd42}, tm);
    chk("wb5_then_mg", 64'(tm - tw), 64'd1);

    // Same-cycle write and read of label 9 forwards
    wb_op(8'd9, bb(5, 6, 7, 8), 19'd1, tw);
    fork
      wb_op(8'd9, bb(1, 2, 3, 4), 19'd8, tw);
      mg_op(8'd9, {bb(1, 2, 3, 4), 19'd8}, tm);
    join
    chk("fwd_same_cycle", 64'(tm), 64'(tw));

    // Emit kept, downstream stalls 5 cycles
    bus.out_ready = 1'b0;
    done_op(8'd5, 19'd40, 1'b1, {bb(10, 20, 3, 7), 19'd42}, td);
    for (int i = 0; i < 20 && !bus.out_valid; i++) @(negedge clk);
    n = bus.out_valid ? 1 : 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.out_valid) n++;
    end
    chk("hold_cycles", 64'(n), 64'd5);
    @(posedge clk); #1 bus.out_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    chk("valid_cleared", 64'(bus.out_valid), 64'd0);
    @(posedge clk); #1;
    mg_op(8'd5, INIT_W, tm);

    // Emit dropped below threshold
    wb_op(8'd5, bb(10, 20, 3, 7), 19'd42, tw);
    done_op(8'd5, 19'd50, 1'b0, '0, td);
    chk("drop_done_ack", 64'(td > 0), 64'd1);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1'b1;
    end
    chk("drop_no_valid", 64'(seen), 64'd0);
    @(posedge clk); #1;
    mg_op(8'd5, INIT_W, tm);

    // Merge, done and write-back all at once on label 7
    wb_op(8'd7, bb(30, 31, 32, 33), 19'd30, tw);
    fork
      mg_op(8'd7, {bb(40, 41, 42, 43), 19'd55}, tm);
      done_op(8'd7, 19'd10, 1'b1,
              {bb(40, 41, 42, 43), 19'd55}, td);
      wb_op(8'd7, bb(40, 41, 42, 43), 19'd55, tw);
    join
    chk("tri_wb_with_mg", 64'(tw), 64'(tm));
    chk("tri_done_after_mg", 64'(td), 64'(tm + 1));
    repeat (4) @(posedge clk);
    #1;
    mg_op(8'd7, INIT_W, tm);

    // Emit clear waits behind a run of write-backs
    fork
      done_op(8'd9, 19'd0, 1'b1, {bb(1, 2, 3, 4), 19'd8}, td);
      begin
        for (int i = 20; i < 24; i++)
          wb_op(8'(i), bb(i, i + 1, i + 2, i + 3),
                19'(100 + i), tw);
      end
    join
    chk("run_last_wb", 64'(tw), 64'(td + 3));
    repeat (4) @(posedge clk);
    #1;
    mg_op(8'd9, INIT_W, tm);
    for (int i = 20; i < 24; i++)
      mg_op(8'(i), {bb(i, i + 1, i + 2, i + 3), 19'(100 + i)}, tm);

    // Write-back to a label in CLR is wiped; a later one sticks
    wb_op(8'd30, bb(50, 51, 52, 53), 19'd5, tw);
    fork
      done_op(8'd30, 19'd0, 1'b1,
              {bb(50, 51, 52, 53), 19'd5}, td);
      begin
        wb_op(8'd40, bb(2, 2, 2, 2), 19'd2, tw);
        wb_op(8'd41, bb(3, 3, 3, 3), 19'd3, tw);
        wb_op(8'd30, bb(9, 9, 9, 9), 19'd77, tw);
      end
    join
    repeat (4) @(posedge clk);
    #1;
    mg_op(8'd30, INIT_W, tm);
    wb_op(8'd30, bb(6, 6, 6, 6), 19'd66, tw);
    mg_op(8'd30, {bb(6, 6, 6, 6), 19'd66}, tm);
    mg_op(8'd40, {bb(2, 2, 2, 2), 19'd2}, tm);
    mg_op(8'd41, {bb(3, 3, 3, 3), 19'd3}, tm);

    // Drain the scoreboard
    for (int i = 0; i < 20; i++) begin
      if (mg_q.size() != 0 || out_q.size() != 0) @(negedge clk);
    end
    chk("mg_q_empty", 64'(mg_q.size()), 64'd0);
    chk("out_q_empty", 64'(out_q.size()), 64'd0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
